// File: rtl/register_pipeline_elastic.sv
// Elastic register chain: DEPTH main+skid slices, flush and occupancy; REG_PIPE_PERF_EN adds stall_cnt/stall_clr.
// Latency DEPTH-1 edges from acceptance to out_valid when not stalled; 1 beat/cycle sustained.
// Backpressure: every slice ready is a flop, in_ready falls only when slice 0 holds two beats.
module register_pipeline_elastic #(
  parameter int N = 32,
  parameter int DEPTH = 2,
  localparam int CNT_W = $clog2(2*DEPTH+1)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             flush,
  input  logic             in_valid,
  input  logic [N-1:0]     in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [N-1:0]     out_data,
  input  logic             out_ready,
  output logic [CNT_W-1:0] occupancy
`ifdef REG_PIPE_PERF_EN
  ,
  input  logic             stall_clr,
  output logic [31:0]      stall_cnt
`endif
);

  logic [DEPTH-1:0] slice_vld;
  logic [DEPTH-1:0] slice_rdy;
  logic [N-1:0]     slice_dat [DEPTH];

  for (genvar k = 0; k < DEPTH; k++) begin : g_slice
    logic         up_vld;
    logic [N-1:0] up_dat;
    logic         dn_rdy;
    logic         push;
    logic         pop;
    logic         main_vld_q, main_vld_d;
    logic         skid_vld_q, skid_vld_d;
    logic         rdy_q, rdy_d;
    logic [N-1:0] main_dat_q, main_dat_d;
    logic [N-1:0] skid_dat_q, skid_dat_d;

    if (k == 0) begin : g_head
      assign up_vld = in_valid;
      assign up_dat = in_data;
    end else begin : g_link
      assign up_vld = slice_vld[k-1];
      assign up_dat = slice_dat[k-1];
    end

    if (k == DEPTH-1) begin : g_tail
      assign dn_rdy = out_ready;
    end else begin : g_mid
      assign dn_rdy = slice_rdy[k+1];
    end

    always_comb begin
      push       = up_vld && rdy_q;
      pop        = main_vld_q && dn_rdy;
      main_vld_d = main_vld_q;
      skid_vld_d = skid_vld_q;
      main_dat_d = main_dat_q;
      skid_dat_d = skid_dat_q;
      if (flush) begin
        main_vld_d = 1'b0;
        skid_vld_d = 1'b0;
      end else if (skid_vld_q) begin
        // FULL: ready is low, so only a pop can happen
        if (pop) begin
          main_dat_d = skid_dat_q;
          skid_vld_d = 1'b0;
        end
      end else if (main_vld_q) begin
        if (push && pop) begin
          main_dat_d = up_dat;
        end else if (push) begin
          skid_dat_d = up_dat;
          skid_vld_d = 1'b1;
        end else if (pop) begin
          main_vld_d = 1'b0;
        end
      end else if (push) begin
        main_dat_d = up_dat;
        main_vld_d = 1'b1;
      end
      // separate flop so ready stays low through reset and rises on the first edge after it
      rdy_d = !skid_vld_d;
    end

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        main_vld_q <= 1'b0;
        skid_vld_q <= 1'b0;
        rdy_q      <= 1'b0;
        main_dat_q <= '0;
        skid_dat_q <= '0;
      end else begin
        main_vld_q <= main_vld_d;
        skid_vld_q <= skid_vld_d;
        rdy_q      <= rdy_d;
        main_dat_q <= main_dat_d;
        skid_dat_q <= skid_dat_d;
      end
    end

    assign slice_vld[k] = main_vld_q;
    assign slice_rdy[k] = rdy_q;
    assign slice_dat[k] = main_dat_q;
  end

  assign in_ready  = slice_rdy[0];
  assign out_valid = slice_vld[DEPTH-1];
  assign out_data  = slice_dat[DEPTH-1];

  logic             up_push;
  logic             dn_pop;
  logic [CNT_W-1:0] occ_q, occ_d;

  always_comb begin
    up_push = in_valid && in_ready;
    dn_pop  = out_valid && out_ready;
    occ_d   = occ_q + CNT_W'(up_push) - CNT_W'(dn_pop);
    if (flush) begin
      occ_d = '0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      occ_q <= '0;
    end else begin
      occ_q <= occ_d;
    end
  end

  assign occupancy = occ_q;

`ifdef REG_PIPE_PERF_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall_clr) begin
      stall_cnt_d = '0;
    end else if (out_valid && !out_ready && (stall_cnt_q != 32'hFFFF_FFFF)) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_register_pipeline_elastic.sv
// Bench for register_pipeline_elastic (N=32, DEPTH=2): vector table, streaming, random scoreboard,
// async reset and, when REG_PIPE_PERF_EN is defined, the stall counter.
module tb_register_pipeline_elastic;

  logic        clk;
  logic        reset_n;
  logic        flush;
  logic        in_valid;
  logic [31:0] in_data;
  logic        in_ready;
  logic        out_valid;
  logic [31:0] out_data;
  logic        out_ready;
  logic [2:0]  occupancy;
`ifdef REG_PIPE_PERF_EN
  logic        stall_clr;
  logic [31:0] stall_cnt;
`endif

  int tests;
  int fails;

  register_pipeline_elastic #(.N(32), .DEPTH(2)) dut (
    .clk(clk),
    .reset_n(reset_n),
    .flush(flush),
    .in_valid(in_valid),
    .in_data(in_data),
    .in_ready(in_ready),
    .out_valid(out_valid),
    .out_data(out_data),
    .out_ready(out_ready),
    .occupancy(occupancy)
`ifdef REG_PIPE_PERF_EN
    ,
    .stall_clr(stall_clr),
    .stall_cnt(stall_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        fl;
    logic        iv;
    logic [31:0] d;
    logic        ordy;
    logic        e_ir;
    logic        e_ov;
    logic [31:0] e_od;
    logic [2:0]  e_occ;
  } vec_t;

  vec_t vt [19];

  function automatic vec_t mkv(logic fl, logic iv, logic [31:0] d, logic ordy,
                               logic e_ir, logic e_ov, logic [31:0] e_od, logic [2:0] e_occ);
    vec_t v;
    v.fl = fl; v.iv = iv; v.d = d; v.ordy = ordy;
    v.e_ir = e_ir; v.e_ov = e_ov; v.e_od = e_od; v.e_occ = e_occ;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not reach the summary");
    $fatal(1, "watchdog");
  end

  logic [31:0] sb [$];
  logic        iv_r, or_r, push, pop;
  logic [31:0] d_r;

  initial begin
    tests = 0;
    fails = 0;
    reset_n = 1'b1;
    flush = 1'b0;
    in_valid = 1'b0;
    in_data = '0;
    out_ready = 1'b0;
`ifdef REG_PIPE_PERF_EN
    stall_clr = 1'b0;
`endif

    // Vector table: inputs applied before an edge, outputs expected after it.
    vt[0]  = mkv(0, 1, 32'hA0, 0,  1, 0, 32'h0,  3'd1);
    vt[1]  = mkv(0, 1, 32'hA1, 0,  1, 1, 32'hA0, 3'd2);
    vt[2]  = mkv(0, 1, 32'hA2, 0,  1, 1, 32'hA0, 3'd3);
    vt[3]  = mkv(0, 1, 32'hA3, 0,  0, 1, 32'hA0, 3'd4);
    vt[4]  = mkv(0, 1, 32'hA4, 0,  0, 1, 32'hA0, 3'd4);
    vt[5]  = mkv(0, 1, 32'hA4, 1,  0, 1, 32'hA1, 3'd3);
    vt[6]  = mkv(0, 1, 32'hA4, 1,  1, 1, 32'hA2, 3'd2);
    vt[7]  = mkv(0, 1, 32'hA4, 1,  1, 1, 32'hA3, 3'd2);
    vt[8]  = mkv(0, 1, 32'hA5, 1,  1, 1, 32'hA4, 3'd2);
    vt[9]  = mkv(0, 0, 32'h0,  1,  1, 1, 32'hA5, 3'd1);
    vt[10] = mkv(0, 0, 32'h0,  1,  1, 0, 32'hA5, 3'd0);
    vt[11] = mkv(0, 1, 32'hB0, 0,  1, 0, 32'hA5, 3'd1);
    vt[12] = mkv(0, 1, 32'hB1, 0,  1, 1, 32'hB0, 3'd2);
    vt[13] = mkv(0, 1, 32'hB2, 0,  1, 1, 32'hB0, 3'd3);
    vt[14] = mkv(1, 1, 32'hB3, 1,  1, 0, 32'hB0, 3'd0);
    vt[15] = mkv(0, 0, 32'h0,  1,  1, 0, 32'hB0, 3'd0);
    vt[16] = mkv(0, 1, 32'hC0, 1,  1, 0, 32'hB0, 3'd1);
    vt[17] = mkv(0, 0, 32'h0,  1,  1, 1, 32'hC0, 3'd1);
    vt[18] = mkv(0, 0, 32'h0,  1,  1, 0, 32'hC0, 3'd0);

    // Asynchronous reset before any clock edge
    #2 reset_n = 1'b0;
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", out_data, 32'd0);
    chk("rst_occupancy", 32'(occupancy), 32'd0);
    @(posedge clk);
    @(posedge clk);
    #4 reset_n = 1'b1;
    #1;
    chk("rel_in_ready_pre_edge", 32'(in_ready), 32'd0);
    tick();
    chk("rel_in_ready_post_edge", 32'(in_ready), 32'd1);

    for (int i = 0; i < 19; i++) begin
      flush = vt[i].fl;
      in_valid = vt[i].iv;
      in_data = vt[i].d;
      out_ready = vt[i].ordy;
      tick();
      chk($sformatf("vec%0d_in_ready", i), 32'(in_ready), 32'(vt[i].e_ir));
      chk($sformatf("vec%0d_out_valid", i), 32'(out_valid), 32'(vt[i].e_ov));
      chk($sformatf("vec%0d_out_data", i), out_data, vt[i].e_od);
      chk($sformatf("vec%0d_occupancy", i), 32'(occupancy), 32'(vt[i].e_occ));
    end
    flush = 1'b0;
    in_valid = 1'b0;

    // Streaming 1..16 with out_ready held high
    out_ready = 1'b1;
    for (int c = 0; c < 18; c++) begin
      in_valid = (c < 16);
      in_data = 32'(c + 1);
      tick();
      chk($sformatf("stream%0d_in_ready", c), 32'(in_ready), 32'd1);
      chk($sformatf("stream%0d_out_valid", c), 32'(out_valid), 32'((c >= 1) && (c <= 16)));
      if ((c >= 1) && (c <= 16)) begin
        chk($sformatf("stream%0d_out_data", c), out_data, 32'(c));
      end
      chk($sformatf("stream%0d_occupancy", c), 32'(occupancy),
          (c == 0) ? 32'd1 : (c <= 15) ? 32'd2 : (c == 16) ? 32'd1 : 32'd0);
    end
    in_valid = 1'b0;

    // Random valid/ready against a scoreboard queue
    for (int c = 0; c < 10000; c++) begin
      iv_r = 1'($urandom_range(0, 1));
      or_r = 1'($urandom_range(0, 1));
      d_r = $urandom;
      in_valid = iv_r;
      in_data = d_r;
      out_ready = or_r;
      push = iv_r && in_ready;
      pop = out_valid && or_r;
      if (out_valid && !or_r && sb.size() != 0) begin
        chk("rand_stall_data", out_data, sb[0]);
      end
      if (pop) begin
        chk("rand_pop_nonempty", 32'(sb.size() != 0), 32'd1);
        if (sb.size() != 0) begin
          chk("rand_order", out_data, sb.pop_front());
        end
      end
      if (push) begin
        sb.push_back(d_r);
      end
      tick();
      chk("rand_occupancy", 32'(occupancy), 32'(sb.size()));
    end

    in_valid = 1'b0;
    out_ready = 1'b1;
    for (int c = 0; c < 40 && sb.size() != 0; c++) begin
      if (out_valid) begin
        chk("drain_order", out_data, sb.pop_front());
      end
      tick();
    end
    chk("drain_empty", 32'(sb.size()), 32'd0);
    chk("drain_occupancy", 32'(occupancy), 32'd0);

    // Reset mid-stream, between edges
    in_valid = 1'b1;
    in_data = 32'hE0;
    tick();
    in_data = 32'hE1;
    tick();
    chk("pre_rst_out_data", out_data, 32'hE0);
    #3 reset_n = 1'b0;
    #1;
    chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_out_data", out_data, 32'd0);
    chk("mid_rst_occupancy", 32'(occupancy), 32'd0);
    chk("mid_rst_in_ready", 32'(in_ready), 32'd0);
    tick();
    chk("hold_rst_in_ready", 32'(in_ready), 32'd0);
    #3 reset_n = 1'b1;
    #1;
    chk("rel2_in_ready_pre_edge", 32'(in_ready), 32'd0);
    tick();
    chk("rel2_in_ready_post_edge", 32'(in_ready), 32'd1);
    chk("rel2_occupancy", 32'(occupancy), 32'd0);
    in_valid = 1'b0;
    tick();
    chk("rel2_no_beat_out_valid", 32'(out_valid), 32'd0);
    chk("rel2_no_beat_occupancy", 32'(occupancy), 32'd0);

`ifdef REG_PIPE_PERF_EN
    out_ready = 1'b0;
    in_valid = 1'b1;
    in_data = 32'hD0;
    tick();
    in_valid = 1'b0;
    tick();
    chk("stall_idle", stall_cnt, 32'd0);
    for (int c = 0; c < 7; c++) begin
      tick();
    end
    chk("stall_seven", stall_cnt, 32'd7);
    stall_clr = 1'b1;
    tick();
    chk("stall_clr_prio", stall_cnt, 32'd0);
    stall_clr = 1'b0;
    tick();
    chk("stall_after_clr", stall_cnt, 32'd1);
    flush = 1'b1;
    tick();
    chk("stall_flush_keeps", stall_cnt, 32'd2);
    flush = 1'b0;
    tick();
    chk("stall_no_valid", stall_cnt, 32'd2);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
